// File: rtl/count_pkg.sv
// Shared defaults and entry sizing for the count capture FIFO.
package count_pkg;

   localparam int DEPTH_DEF = 4;
   localparam int CW_DEF    = 8;
   localparam int ENTRY_W   = CW_DEF + 1;

   // Entry width: wrap flag on top of the captured count.
   function automatic int entry_w(input int cw);
      return cw + 1;
   endfunction

endpackage

// File: rtl/count_wrap_det.sv
// Wrap detector: remembers last cycle's count and flags an all-ones -> zero step.
module count_wrap_det #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CW-1:0] count_i,
   output logic          wrap_o
);

   logic [CW-1:0] prev_count_q;
   logic [CW-1:0] prev_count_d;

   assign prev_count_d = count_i;

   // Previous count resets to zero, so a zero count right after reset never looks like a wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_count_q <= '0;
      else       prev_count_q <= prev_count_d;
   end

   assign wrap_o = (prev_count_q == {CW{1'b1}}) && (count_i == '0);

endmodule

// File: rtl/count_capture_fifo.sv
// Captures the free-running count on trig into a small FIFO, tagging each entry
// with whether the counter wrapped since the previous accepted capture.
module count_capture_fifo
   import count_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [CW-1:0]          count,
   input  logic                   trig,
   input  logic                   clear,
   input  logic                   rd_ready,
   output logic                   rd_valid,
   output logic [CW:0]            rd_data,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow
);

   localparam int EW = entry_w(CW);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic          wrap_now;
   logic          pop;
   logic          push;
   logic          drop;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q,  level_d;
   logic          wpend_q,  wpend_d;
   logic          ovf_q,    ovf_d;

   count_wrap_det #(.CW(CW)) u_wrap_det (
      .clk     (clk),
      .reset   (reset),
      .count_i (count),
      .wrap_o  (wrap_now)
   );

   assign rd_valid = (level_q != '0);
   assign pop      = rd_valid && rd_ready;
   // A full FIFO still accepts a capture when the head leaves in the same cycle.
   assign push     = trig && ((level_q != FULL_LVL) || pop);
   assign drop     = trig && !push;

   // Next-state for pointers, occupancy and flags; clear beats push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      wpend_d  = wpend_q;
      ovf_d    = ovf_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         wpend_d  = 1'b0;
         ovf_d    = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
         // A dropped capture does not consume the pending wrap.
         if (push)          wpend_d = 1'b0;
         else if (wrap_now) wpend_d = 1'b1;
         if (drop)          ovf_d   = 1'b1;
      end
   end

   // Control state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         wpend_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         wpend_q  <= wpend_d;
         ovf_q    <= ovf_d;
      end
   end

   // Entry storage; contents are only observed through valid slots, so no reset.
   always_ff @(posedge clk) begin
      if (push && !clear) mem_q[wr_ptr_q] <= {wpend_q | wrap_now, count};
   end

   assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign level    = level_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Bench for count_capture_fifo: directed vector table, corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_count_capture_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] count;
   logic       trig, clear, rd_ready;
   logic       rd_valid;
   logic [8:0] rd_data;
   logic [2:0] level;
   logic       overflow;

   int n_pass = 0;
   int n_total = 0;

   count_capture_fifo #(.DEPTH(4), .CW(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .count    (count),
      .trig     (trig),
      .clear    (clear),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .level    (level),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] cnt;
      logic       trg, clr, rdy;
      logic       vld;
      logic [8:0] dat;
      logic [2:0] lvl;
      logic       ovf;
   } vec_t;

   vec_t vecs[18];

   // reference model state
   logic [8:0] mq[$];
   logic       m_ovf, m_wp;
   logic [7:0] m_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [8:0] d,
                          input logic [2:0] l, input logic o);
      chk({tag, " rd_valid"}, 32'(rd_valid), 32'(v));
      chk({tag, " rd_data"},  32'(rd_data),  32'(d));
      chk({tag, " level"},    32'(level),    32'(l));
      chk({tag, " overflow"}, 32'(overflow), 32'(o));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] c, input logic t, input logic cl, input logic r);
      count = c; trig = t; clear = cl; rd_ready = r;
   endtask

   function automatic vec_t mk(input logic [7:0] c, input logic t, input logic cl, input logic r,
                               input logic v, input logic [8:0] d, input logic [2:0] l, input logic o);
      vec_t x;
      x.cnt = c; x.trg = t; x.clr = cl; x.rdy = r;
      x.vld = v; x.dat = d; x.lvl = l; x.ovf = o;
      return x;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0; m_wp = 1'b0; m_prev = 8'h00;
   endtask

   // One clock of behaviour, from the current inputs.
   task automatic model_step();
      logic wrap, pop, acc;
      wrap = (m_prev == 8'hFF) && (count == 8'h00);
      pop  = (mq.size() > 0) && rd_ready;
      if (clear) begin
         mq.delete();
         m_ovf = 1'b0; m_wp = 1'b0;
      end else begin
         acc = trig && ((mq.size() < 4) || pop);
         if (pop) void'(mq.pop_front());
         if (acc) begin
            mq.push_back({m_wp | wrap, count});
            m_wp = 1'b0;
         end else if (wrap) m_wp = 1'b1;
         if (trig && !acc) m_ovf = 1'b1;
      end
      m_prev = count;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      drive(8'h00, 0, 0, 0);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] cur;
      reset = 1'b1;
      drive(8'h00, 0, 0, 0);

      vecs[0]  = mk(8'h12, 1, 0, 1, 1, 9'h012, 3'd1, 0);
      vecs[1]  = mk(8'h13, 0, 0, 1, 0, 9'h000, 3'd0, 0);
      vecs[2]  = mk(8'hFF, 0, 0, 1, 0, 9'h000, 3'd0, 0);
      vecs[3]  = mk(8'h00, 0, 0, 1, 0, 9'h000, 3'd0, 0);
      vecs[4]  = mk(8'h01, 0, 0, 1, 0, 9'h000, 3'd0, 0);
      vecs[5]  = mk(8'h03, 1, 0, 0, 1, 9'h103, 3'd1, 0);
      vecs[6]  = mk(8'h07, 1, 0, 1, 1, 9'h007, 3'd1, 0);
      vecs[7]  = mk(8'h08, 0, 0, 1, 0, 9'h000, 3'd0, 0);
      vecs[8]  = mk(8'h01, 1, 0, 0, 1, 9'h001, 3'd1, 0);
      vecs[9]  = mk(8'h02, 1, 0, 0, 1, 9'h001, 3'd2, 0);
      vecs[10] = mk(8'h03, 1, 0, 0, 1, 9'h001, 3'd3, 0);
      vecs[11] = mk(8'h04, 1, 0, 0, 1, 9'h001, 3'd4, 0);
      vecs[12] = mk(8'h05, 1, 0, 0, 1, 9'h001, 3'd4, 1);
      vecs[13] = mk(8'h06, 0, 0, 1, 1, 9'h002, 3'd3, 1);
      vecs[14] = mk(8'h07, 0, 0, 1, 1, 9'h003, 3'd2, 1);
      vecs[15] = mk(8'h08, 0, 0, 1, 1, 9'h004, 3'd1, 1);
      vecs[16] = mk(8'h09, 0, 0, 1, 0, 9'h000, 3'd0, 1);
      vecs[17] = mk(8'h0A, 0, 1, 0, 0, 9'h000, 3'd0, 0);

      tick();
      chk_all("reset_state", 0, 9'h000, 3'd0, 0);
      tick();
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].cnt, vecs[i].trg, vecs[i].clr, vecs[i].rdy);
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].vld, vecs[i].dat, vecs[i].lvl, vecs[i].ovf);
      end

      // push and pop together while full
      for (int i = 0; i < 4; i++) begin
         drive(8'h21 + 8'(i), 1, 0, 0);
         tick();
      end
      chk_all("full_fill", 1, 9'h021, 3'd4, 0);
      drive(8'h25, 1, 0, 1);
      tick();
      chk_all("full_pushpop", 1, 9'h022, 3'd4, 0);
      drive(8'h26, 0, 0, 1);
      for (int i = 0; i < 3; i++) tick();
      chk_all("full_order", 1, 9'h025, 3'd1, 0);

      // clear beats a same-cycle capture
      drive(8'h30, 0, 1, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(8'h31 + 8'(i), 1, 0, 0);
         tick();
      end
      chk_all("pre_clear", 1, 9'h031, 3'd3, 0);
      drive(8'h40, 1, 1, 1);
      tick();
      chk_all("clear_prio", 0, 9'h000, 3'd0, 0);

      // async reset mid-cycle, then capture right after release with count = 0
      for (int i = 0; i < 2; i++) begin
         drive(8'h50 + 8'(i), 1, 0, 0);
         tick();
      end
      chk_all("pre_reset", 1, 9'h050, 3'd2, 0);
      drive(8'hFF, 0, 0, 0);
      #3;
      reset = 1'b1;
      #1;
      chk_all("async_reset", 0, 9'h000, 3'd0, 0);
      tick();
      tick();
      reset = 1'b0;
      drive(8'h00, 1, 0, 0);
      tick();
      chk_all("first_after_reset", 1, 9'h000, 3'd1, 0);
      drive(8'h03, 1, 0, 1);
      tick();
      chk_all("after_reset_next", 1, 9'h003, 3'd1, 0);

      // randomized traffic against the model
      pulse_reset();
      model_reset();
      cur = 8'h00;
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 15));
         if (r == 0)      cur = 8'hFF;
         else if (r == 1) cur = 8'($urandom);
         else             cur = cur + 8'd1;
         count    = cur;
         trig     = ($urandom_range(0, 2) != 0);
         rd_ready = ($urandom_range(0, 3) > (n % 400 < 200 ? 0 : 2));
         clear    = ($urandom_range(0, 99) == 0);
         model_step();
         tick();
         chk_all("rand", (mq.size() > 0), (mq.size() > 0) ? mq[0] : 9'h000,
                 3'(mq.size()), m_ovf);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
